// File: rtl/ddram_rd_arbiter.sv
// Two-requester byte read arbiter over one 64-bit DDRAM read channel, round-robin on misses.
// Optional per-requester line buffers enabled by defining DDRAM_RD_ARB_LINE_CACHE_EN.
//
// state  | meaning
// S_IDLE | no DDRAM access in flight; grant a pending requester
// S_WAIT | DDRAM read outstanding for the granted requester

module ddram_rd_arbiter #(
   parameter int AW = 18
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          flush,
   input  logic [AW-1:0] a_addr,
   input  logic          a_rd,
   output logic [7:0]    a_data,
   output logic          a_rdy,
   input  logic [AW-1:0] b_addr,
   input  logic          b_rd,
   output logic [7:0]    b_data,
   output logic          b_rdy,
   output logic [AW-1:0] mem_addr,
   output logic          mem_req,
   input  logic          mem_ready,
   input  logic [63:0]   mem_dout
);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t state, state_nxt;
   logic   grant, grant_nxt;     // 0 = A, 1 = B
   logic   last_grant;
   logic   hit_a, hit_b;
   logic   pend_a, pend_b;
   logic   start, fill;
   logic [7:0] hit_byte_a, hit_byte_b;
   logic [7:0] fill_byte_a, fill_byte_b;
   logic [AW-1:0] sel_addr;

   assign fill_byte_a = mem_dout[{a_addr[2:0], 3'b000} +: 8];
   assign fill_byte_b = mem_dout[{b_addr[2:0], 3'b000} +: 8];

`ifdef DDRAM_RD_ARB_LINE_CACHE_EN
   logic          valid_a, valid_b;
   logic          kill;
   logic [AW-4:0] tag_a, tag_b;
   logic [63:0]   line_a, line_b;

   // The granted requester never hits while its own fill is outstanding, so it cannot double-pulse.
   assign hit_a = a_rd && !a_rdy && valid_a && (tag_a == a_addr[AW-1:3]) &&
                  !(state == S_WAIT && grant == 1'b0);
   assign hit_b = b_rd && !b_rdy && valid_b && (tag_b == b_addr[AW-1:3]) &&
                  !(state == S_WAIT && grant == 1'b1);
   assign hit_byte_a = line_a[{a_addr[2:0], 3'b000} +: 8];
   assign hit_byte_b = line_b[{b_addr[2:0], 3'b000} +: 8];

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         valid_a <= 1'b0;
         valid_b <= 1'b0;
         kill    <= 1'b0;
         tag_a   <= '0;
         tag_b   <= '0;
         line_a  <= '0;
         line_b  <= '0;
      end else begin
         if (start)
            kill <= 1'b0;
         else if (flush && state == S_WAIT)
            kill <= 1'b1;
         if (fill && grant == 1'b0) begin
            line_a  <= mem_dout;
            tag_a   <= mem_addr[AW-1:3];
            valid_a <= !(kill || flush);
         end else if (flush) begin
            valid_a <= 1'b0;
         end
         if (fill && grant == 1'b1) begin
            line_b  <= mem_dout;
            tag_b   <= mem_addr[AW-1:3];
            valid_b <= !(kill || flush);
         end else if (flush) begin
            valid_b <= 1'b0;
         end
      end
   end
`else
   logic unused_flush;
   assign unused_flush = flush;
   assign hit_a        = 1'b0;
   assign hit_b        = 1'b0;
   assign hit_byte_a   = 8'h00;
   assign hit_byte_b   = 8'h00;
`endif

   // A rdy pulse blocks re-evaluation for one cycle so a held x_rd is not served twice.
   assign pend_a = a_rd && !a_rdy && !hit_a;
   assign pend_b = b_rd && !b_rdy && !hit_b;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         grant <= 1'b0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      case (state)
         S_IDLE: begin
            if (pend_a || pend_b) begin
               state_nxt = S_WAIT;
               grant_nxt = (pend_a && pend_b) ? !last_grant : pend_b;
            end
         end
         S_WAIT: begin
            if (mem_ready)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      start    = (state == S_IDLE) && (pend_a || pend_b);
      fill     = (state == S_WAIT) && mem_ready;
      sel_addr = grant_nxt ? b_addr : a_addr;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         last_grant <= 1'b1;
         a_rdy      <= 1'b0;
         b_rdy      <= 1'b0;
         a_data     <= 8'h00;
         b_data     <= 8'h00;
      end else begin
         a_rdy <= 1'b0;
         b_rdy <= 1'b0;
         if (start) begin
            mem_req  <= 1'b1;
            mem_addr <= {sel_addr[AW-1:3], 3'b000};
         end
         if (fill) begin
            mem_req    <= 1'b0;
            last_grant <= grant;
         end
         if (fill && grant == 1'b0) begin
            a_data <= fill_byte_a;
            a_rdy  <= a_rd;
         end else if (hit_a) begin
            a_data <= hit_byte_a;
            a_rdy  <= 1'b1;
         end
         if (fill && grant == 1'b1) begin
            b_data <= fill_byte_b;
            b_rdy  <= b_rd;
         end else if (hit_b) begin
            b_data <= hit_byte_b;
            b_rdy  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ddram_rd_arbiter.sv
// Directed bench for ddram_rd_arbiter with a fixed-latency DDRAM model.
// Expectations adapt to DDRAM_RD_ARB_LINE_CACHE_EN being defined or not.

module tb_ddram_rd_arbiter;

   localparam int AW      = 18;
   localparam int MEM_LAT = 5;
`ifdef DDRAM_RD_ARB_LINE_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic          clk_sys = 1'b0;
   logic          reset_n = 1'b0;
   logic          flush   = 1'b0;
   logic [AW-1:0] a_addr  = '0;
   logic          a_rd    = 1'b0;
   logic [7:0]    a_data;
   logic          a_rdy;
   logic [AW-1:0] b_addr  = '0;
   logic          b_rd    = 1'b0;
   logic [7:0]    b_data;
   logic          b_rdy;
   logic [AW-1:0] mem_addr;
   logic          mem_req;
   logic          mem_ready = 1'b0;
   logic [63:0]   mem_dout  = '0;

   int n_checks = 0;
   int n_errors = 0;
   int lat_cnt = 0;
   int stray_cnt = 0;
   int stray_done = 0;

   ddram_rd_arbiter #(.AW(AW)) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .flush     (flush),
      .a_addr    (a_addr),
      .a_rd      (a_rd),
      .a_data    (a_data),
      .a_rdy     (a_rdy),
      .b_addr    (b_addr),
      .b_rd      (b_rd),
      .b_data    (b_data),
      .b_rdy     (b_rdy),
      .mem_addr  (mem_addr),
      .mem_req   (mem_req),
      .mem_ready (mem_ready),
      .mem_dout  (mem_dout)
   );

   always #5 clk_sys = ~clk_sys;

   // Byte n of line L is ((n+1)*0x11) ^ (L[10:3]-2): line 0x10 reads 0x8877665544332211.
   function automatic logic [7:0] exp_byte(input logic [AW-1:0] addr);
      logic [7:0] l;
      logic [7:0] n;
      l = addr[10:3] - 8'd2;
      n = {5'd0, addr[2:0]} + 8'd1;
      return 8'(n * 8'h11) ^ l;
   endfunction

   function automatic logic [63:0] line_data(input logic [AW-1:0] la);
      logic [63:0] d;
      logic [AW-1:0] x;
      d = '0;
      for (int n = 0; n < 8; n++) begin
         x = {la[AW-1:3], 3'(n)};
         d[8*n +: 8] = exp_byte(x);
      end
      return d;
   endfunction

   always @(posedge clk_sys) begin
      #1;
      if (mem_ready) begin
         mem_ready = 1'b0;
      end else if (stray_cnt != stray_done) begin
         stray_done = stray_done + 1;
         mem_dout   = 64'hDEAD_BEEF_0BAD_F00D;
         mem_ready  = 1'b1;
      end else if (mem_req) begin
         if (lat_cnt == MEM_LAT) begin
            mem_dout  = line_data(mem_addr);
            mem_ready = 1'b1;
            lat_cnt   = 0;
         end else begin
            lat_cnt = lat_cnt + 1;
         end
      end else begin
         lat_cnt = 0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      a_rd    = 1'b0;
      b_rd    = 1'b0;
      flush   = 1'b0;
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   // Steps until every wanted requester has pulsed rdy; drops its rd on the pulse.
   task automatic run_pair(input bit want_a, input bit want_b, input int budget,
                           output int ta, output int tb_, output logic [7:0] da,
                           output logic [7:0] db, output bit saw_req,
                           output logic [AW-1:0] req_addr);
      bit done_a, done_b;
      int n;
      ta = -1; tb_ = -1; da = '0; db = '0; saw_req = 1'b0; req_addr = '0;
      done_a = !want_a;
      done_b = !want_b;
      n = 0;
      while (!(done_a && done_b) && n < budget) begin
         step();
         n++;
         if (mem_req && !saw_req) begin
            saw_req  = 1'b1;
            req_addr = mem_addr;
         end
         if (!done_a && a_rdy) begin
            done_a = 1'b1; ta = n; da = a_data; a_rd = 1'b0;
         end
         if (!done_b && b_rdy) begin
            done_b = 1'b1; tb_ = n; db = b_data; b_rd = 1'b0;
         end
      end
      check("rdy_done", {62'd0, done_a, done_b}, 64'd3);
   endtask

   int ta, tb_;
   logic [7:0] da, db;
   bit saw_req;
   logic [AW-1:0] req_addr;
   bit any_rdy, any_req;

   initial begin
      do_reset();
      check("rst_a_rdy", a_rdy, 0);
      check("rst_b_rdy", b_rdy, 0);
      check("rst_a_data", a_data, 0);
      check("rst_b_data", b_data, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);

      // single miss on A
      a_addr = 18'h00010; a_rd = 1'b1;
      run_pair(1, 0, 40, ta, tb_, da, db, saw_req, req_addr);
      check("t1_lat", ta, 7);
      check("t1_data", da, 8'h11);
      check("t1_mem_addr", req_addr, 18'h00010);

      // same line again: hit when buffered, otherwise a fresh access
      step();
      a_addr = 18'h00013; a_rd = 1'b1;
      run_pair(1, 0, 40, ta, tb_, da, db, saw_req, req_addr);
      check("t2_lat", ta, CACHE ? 1 : 7);
      check("t2_data", da, 8'h44);
      check("t2_mem_req", saw_req, !CACHE);

      // simultaneous misses after reset: A first (last_grant=B)
      do_reset();
      a_addr = 18'h00100; b_addr = 18'h00208; a_rd = 1'b1; b_rd = 1'b1;
      run_pair(1, 1, 60, ta, tb_, da, db, saw_req, req_addr);
      check("t3_a_lat", ta, 7);
      check("t3_b_lat", tb_, 14);
      check("t3_a_data", da, exp_byte(18'h00100));
      check("t3_b_data", db, exp_byte(18'h00208));
      check("t3_first_addr", req_addr, 18'h00100);

      // B reads its buffered line while A's miss is in flight
      step();
      a_addr = 18'h00800; a_rd = 1'b1;
      step(); step(); step();
      b_addr = 18'h00208; b_rd = 1'b1;
      step();
      check("t4_b_hit", b_rdy, CACHE);
      check("t4_b_data", b_data, exp_byte(18'h00208));
      check("t4_mem_req", mem_req, 1);
      check("t4_mem_addr", mem_addr, 18'h00800);
      if (b_rdy) b_rd = 1'b0;
      run_pair(1, b_rd, 60, ta, tb_, da, db, saw_req, req_addr);
      check("t4_a_lat", ta, 3);
      check("t4_a_data", da, exp_byte(18'h00800));
      check("t4_b_lat", tb_, CACHE ? -1 : 10);

      // after an A fill, simultaneous misses serve B first
      step();
      a_addr = 18'h00900; a_rd = 1'b1;
      run_pair(1, 0, 40, ta, tb_, da, db, saw_req, req_addr);
      check("t3b_single", ta, 7);
      step();
      a_addr = 18'h00A00; b_addr = 18'h00B0D; a_rd = 1'b1; b_rd = 1'b1;
      run_pair(1, 1, 60, ta, tb_, da, db, saw_req, req_addr);
      check("t3b_b_lat", tb_, 7);
      check("t3b_a_lat", ta, 14);
      check("t3b_first_addr", req_addr, 18'h00B08);
      check("t3b_b_data", db, exp_byte(18'h00B0D));

      // flush during WAIT: byte still delivered, line not kept
      step();
      a_addr = 18'h00C05; a_rd = 1'b1;
      step(); step(); step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      run_pair(1, 0, 40, ta, tb_, da, db, saw_req, req_addr);
      check("t5_lat", ta, 3);
      check("t5_data", da, exp_byte(18'h00C05));
      step();
      a_addr = 18'h00C02; a_rd = 1'b1;
      run_pair(1, 0, 40, ta, tb_, da, db, saw_req, req_addr);
      check("t5_refetch_req", saw_req, 1);
      check("t5_refetch_lat", ta, 7);
      check("t5_refetch_data", da, exp_byte(18'h00C02));

      // flush coinciding with mem_ready: kill wins
      step();
      a_addr = 18'h00D01; a_rd = 1'b1;
      for (int i = 0; i < 6; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      a_rd  = 1'b0;
      check("t5b_rdy", a_rdy, 1);
      check("t5b_data", a_data, exp_byte(18'h00D01));
      step();
      a_addr = 18'h00D03; a_rd = 1'b1;
      run_pair(1, 0, 40, ta, tb_, da, db, saw_req, req_addr);
      check("t5b_refetch_req", saw_req, 1);
      check("t5b_refetch_lat", ta, 7);

      // reset mid-WAIT, then a stray mem_ready after release
      step();
      a_addr = 18'h00E00; a_rd = 1'b1;
      step(); step(); step();
      reset_n = 1'b0;
      #2;
      check("t6_req_async", mem_req, 0);
      a_rd = 1'b0;
      step();
      reset_n = 1'b1;
      stray_cnt = stray_cnt + 1;
      any_rdy = 1'b0;
      any_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         any_rdy |= a_rdy | b_rdy;
         any_req |= mem_req;
      end
      check("t6_stray_rdy", any_rdy, 0);
      check("t6_stray_req", any_req, 0);
      a_addr = 18'h00D04; a_rd = 1'b1;
      run_pair(1, 0, 40, ta, tb_, da, db, saw_req, req_addr);
      check("t6_invalid_req", saw_req, 1);
      check("t6_invalid_lat", ta, 7);
      check("t6_invalid_data", da, exp_byte(18'h00D04));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
